// File: rtl/hid_key_sequencer.sv
// Periodic HID keystroke source: application FIFO keys take priority,
// otherwise an increment-wrap or ping-pong generator supplies the key.
module hid_key_sequencer #(
    parameter int unsigned       CLK_HZ      = 60000000,
    parameter int unsigned       INTERVAL_MS = 2000,
    parameter int unsigned       KEY_W       = 16,
    parameter logic [KEY_W-1:0]  KEY_FIRST   = KEY_W'(16'h0004),
    parameter logic [KEY_W-1:0]  KEY_LAST    = KEY_W'(16'h0027),
    parameter bit                MODE        = 1'b0,
    parameter int unsigned       FIFO_DEPTH  = 8
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic                              enable,
    input  logic                              auto_en,
    input  logic [KEY_W-1:0]                  in_key,
    input  logic                              in_valid,
    output logic                              in_ready,
    output logic [KEY_W-1:0]                  key_value,
    output logic                              key_request,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level
);

    localparam int unsigned PERIOD = CLK_HZ / 1000 * INTERVAL_MS;
    localparam int unsigned CNT_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W  = $clog2(FIFO_DEPTH + 1);

    if (PERIOD < 2) begin : g_bad_period
        $error("hid_key_sequencer: PERIOD must be at least 2 cycles");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("hid_key_sequencer: FIFO_DEPTH must be a power of 2 and >= 2");
    end
    if (KEY_LAST < KEY_FIRST) begin : g_bad_range
        $error("hid_key_sequencer: KEY_LAST must not be below KEY_FIRST");
    end

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick;

    logic [KEY_W-1:0] mem_q [FIFO_DEPTH];
    logic [KEY_W-1:0] mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d;
    logic [PTR_W-1:0] rd_q, rd_d;
    logic [LVL_W-1:0] count_q, count_d;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;

    logic [KEY_W-1:0] gen_q, gen_d;
    logic             dir_q, dir_d;
    logic             gen_use;

    logic [KEY_W-1:0] key_val_q, key_val_d;
    logic             key_req_q, key_req_d;

    // Interval counter: wraps at PERIOD-1 and raises tick on that cycle.
    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (!enable) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_W'(PERIOD - 1)) begin
            tick  = 1'b1;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign full     = (count_q == LVL_W'(FIFO_DEPTH));
    assign empty    = (count_q == '0);
    assign in_ready = !full && rstn;
    assign push     = in_valid && in_ready;
    // Emptiness comes from the registered level, so a key pushed on the
    // tick cycle itself is only visible to the following tick.
    assign pop      = tick && !empty;
    assign gen_use  = tick && empty && auto_en;

    // FIFO pointer, level and storage update.
    always_comb begin
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        if (push) begin
            mem_d[wr_q] = in_key;
            wr_d        = wr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_d = rd_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + LVL_W'(1);
            2'b01:   count_d = count_q - LVL_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Generator step, taken only when the generator supplies the key.
    always_comb begin
        gen_d = gen_q;
        dir_d = dir_q;
        if (gen_use && (KEY_FIRST != KEY_LAST)) begin
            if (!MODE) begin
                if (gen_q == KEY_LAST) begin
                    gen_d = KEY_FIRST;
                end else begin
                    gen_d = gen_q + KEY_W'(1);
                end
            end else if (!dir_q) begin
                if (gen_q == KEY_LAST) begin
                    dir_d = 1'b1;
                    gen_d = gen_q - KEY_W'(1);
                end else begin
                    gen_d = gen_q + KEY_W'(1);
                end
            end else begin
                if (gen_q == KEY_FIRST) begin
                    dir_d = 1'b0;
                    gen_d = gen_q + KEY_W'(1);
                end else begin
                    gen_d = gen_q - KEY_W'(1);
                end
            end
        end
    end

    // Emission select: FIFO head first, generator second, else hold.
    always_comb begin
        key_val_d = key_val_q;
        key_req_d = 1'b0;
        unique case (1'b1)
            pop: begin
                key_val_d = mem_q[rd_q];
                key_req_d = 1'b1;
            end
            gen_use: begin
                key_val_d = gen_q;
                key_req_d = 1'b1;
            end
            default: begin
                key_val_d = key_val_q;
                key_req_d = 1'b0;
            end
        endcase
    end

    // Control state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_q     <= '0;
            wr_q      <= '0;
            rd_q      <= '0;
            count_q   <= '0;
            gen_q     <= KEY_FIRST;
            dir_q     <= 1'b0;
            key_val_q <= '0;
            key_req_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            count_q   <= count_d;
            gen_q     <= gen_d;
            dir_q     <= dir_d;
            key_val_q <= key_val_d;
            key_req_q <= key_req_d;
        end
    end

    // Queue storage; contents are don't-care once the pointers reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign key_value   = key_val_q;
    assign key_request = key_req_q;
    assign fifo_level  = count_q;

endmodule

// File: tb/tb_hid_key_sequencer.sv
// Directed bench for hid_key_sequencer: one increment-wrap and one
// ping-pong instance, PERIOD = 5 cycles, keys 4..6.
module tb_hid_key_sequencer;

    logic        clk;
    logic        rstn;
    logic        enable;
    logic        auto_en;
    logic [15:0] in_key;
    logic        in_valid;

    logic        rdy0, req0;
    logic [15:0] val0;
    logic [2:0]  lvl0;
    logic        rdy1, req1;
    logic [15:0] val1;
    logic [3:0]  lvl1;

    int passed = 0;
    int total  = 0;
    logic [15:0] last0, last1;
    bit chk1;

    typedef struct {
        logic [15:0] v0;
        logic [15:0] v1;
    } vec_t;
    vec_t tbl [6];

    hid_key_sequencer #(
        .CLK_HZ(1000), .INTERVAL_MS(5), .KEY_W(16),
        .KEY_FIRST(16'h0004), .KEY_LAST(16'h0006),
        .MODE(1'b0), .FIFO_DEPTH(4)
    ) u_m0 (
        .clk(clk), .rstn(rstn), .enable(enable), .auto_en(auto_en),
        .in_key(in_key), .in_valid(in_valid), .in_ready(rdy0),
        .key_value(val0), .key_request(req0), .fifo_level(lvl0)
    );

    hid_key_sequencer #(
        .CLK_HZ(1000), .INTERVAL_MS(5), .KEY_W(16),
        .KEY_FIRST(16'h0004), .KEY_LAST(16'h0006),
        .MODE(1'b1), .FIFO_DEPTH(8)
    ) u_m1 (
        .clk(clk), .rstn(rstn), .enable(enable), .auto_en(auto_en),
        .in_key(in_key), .in_valid(in_valid), .in_ready(rdy1),
        .key_value(val1), .key_request(req1), .fifo_level(lvl1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic quiet(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            chk("req0_idle", 32'(req0), 32'd0);
            chk("val0_hold", 32'(val0), 32'(last0));
            if (chk1) begin
                chk("req1_idle", 32'(req1), 32'd0);
                chk("val1_hold", 32'(val1), 32'(last1));
            end
        end
    endtask

    task automatic pulse(input logic [15:0] e0, input logic [15:0] e1);
        step();
        chk("req0_pulse", 32'(req0), 32'd1);
        chk("val0_pulse", 32'(val0), 32'(e0));
        last0 = e0;
        if (chk1) begin
            chk("req1_pulse", 32'(req1), 32'd1);
            chk("val1_pulse", 32'(val1), 32'(e1));
            last1 = e1;
        end
    endtask

    task automatic do_reset(input logic en, input logic aen);
        rstn     = 1'b0;
        enable   = en;
        auto_en  = aen;
        in_valid = 1'b0;
        step();
        chk("rst_req0", 32'(req0), 32'd0);
        chk("rst_val0", 32'(val0), 32'd0);
        chk("rst_lvl0", 32'(lvl0), 32'd0);
        chk("rst_rdy0", 32'(rdy0), 32'd0);
        chk("rst_req1", 32'(req1), 32'd0);
        chk("rst_lvl1", 32'(lvl1), 32'd0);
        rstn  = 1'b1;
        last0 = 16'h0;
        last1 = 16'h0;
        #1;
        chk("rdy0_after_rst", 32'(rdy0), 32'd1);
    endtask

    initial begin
        tbl[0] = '{16'h0004, 16'h0004};
        tbl[1] = '{16'h0005, 16'h0005};
        tbl[2] = '{16'h0006, 16'h0006};
        tbl[3] = '{16'h0004, 16'h0005};
        tbl[4] = '{16'h0005, 16'h0004};
        tbl[5] = '{16'h0006, 16'h0005};

        rstn     = 1'b0;
        enable   = 1'b0;
        auto_en  = 1'b0;
        in_key   = 16'h0;
        in_valid = 1'b0;
        chk1     = 1'b1;
        last0    = 16'h0;
        last1    = 16'h0;

        // Generator order, both modes, pulses at 5,10,...,30.
        do_reset(1'b1, 1'b1);
        for (int i = 0; i < 6; i++) begin
            quiet(4);
            pulse(tbl[i].v0, tbl[i].v1);
        end

        // FIFO keys take priority and leave the generator alone.
        do_reset(1'b1, 1'b1);
        quiet(4);
        pulse(16'h0004, 16'h0004);
        in_valid = 1'b1;
        in_key   = 16'h001E;
        quiet(1);
        in_key   = 16'h001F;
        quiet(1);
        in_valid = 1'b0;
        chk("lvl0_two", 32'(lvl0), 32'd2);
        chk("lvl1_two", 32'(lvl1), 32'd2);
        quiet(2);
        pulse(16'h001E, 16'h001E);
        quiet(4);
        pulse(16'h001F, 16'h001F);
        chk("lvl0_drained", 32'(lvl0), 32'd0);
        quiet(4);
        pulse(16'h0005, 16'h0005);
        quiet(4);
        pulse(16'h0006, 16'h0006);

        // auto_en=0 with empty FIFO is silent; a push on the tick
        // cycle is too late for that tick.
        do_reset(1'b1, 1'b0);
        quiet(15);
        auto_en = 1'b1;
        quiet(4);
        in_valid = 1'b1;
        in_key   = 16'h0033;
        pulse(16'h0004, 16'h0004);
        in_valid = 1'b0;
        chk("lvl0_late_push", 32'(lvl0), 32'd1);
        quiet(4);
        pulse(16'h0033, 16'h0033);
        quiet(4);
        pulse(16'h0005, 16'h0005);

        // Reset mid-period discards the queue and the generator state.
        do_reset(1'b1, 1'b1);
        quiet(4);
        pulse(16'h0004, 16'h0004);
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_key = 16'h0021 + 16'(k);
            quiet(1);
        end
        in_valid = 1'b0;
        chk("lvl0_three", 32'(lvl0), 32'd3);
        chk("lvl1_three", 32'(lvl1), 32'd3);
        do_reset(1'b1, 1'b1);
        quiet(4);
        pulse(16'h0004, 16'h0004);

        // Full FIFO back-pressure on the depth-4 instance only.
        chk1 = 1'b0;
        do_reset(1'b0, 1'b0);
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_key = 16'h0010 + 16'(i);
            chk("rdy0_fill", 32'(rdy0), 32'd1);
            step();
        end
        in_key = 16'h0014;
        chk("rdy0_full", 32'(rdy0), 32'd0);
        chk("lvl0_full", 32'(lvl0), 32'd4);
        step();
        chk("rdy0_full_hold", 32'(rdy0), 32'd0);
        chk("lvl0_full_hold", 32'(lvl0), 32'd4);
        in_valid = 1'b0;
        enable   = 1'b1;
        quiet(4);
        chk("rdy0_full_tick", 32'(rdy0), 32'd0);
        pulse(16'h0010, 16'h0000);
        chk("lvl0_pop1", 32'(lvl0), 32'd3);
        chk("rdy0_reopen", 32'(rdy0), 32'd1);
        quiet(4);
        in_valid = 1'b1;
        in_key   = 16'h0014;
        pulse(16'h0011, 16'h0000);
        in_valid = 1'b0;
        chk("lvl0_push_pop", 32'(lvl0), 32'd3);
        quiet(4);
        pulse(16'h0012, 16'h0000);
        chk("lvl0_pop3", 32'(lvl0), 32'd2);
        quiet(4);
        pulse(16'h0013, 16'h0000);
        quiet(4);
        pulse(16'h0014, 16'h0000);
        chk("lvl0_empty", 32'(lvl0), 32'd0);
        quiet(10);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
